// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
//   Shared definitions for the key debounce block:
//     - key_state_e  : per-channel FSM state (2-bit encoding)
//     - PRESS_CNT_W  : width of each key's wrapping press counter
//     - clog2()      : constant helper used to size the channel counters
// -----------------------------------------------------------------------------
package key_debounce_pkg;

    localparam int PRESS_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,   // key released, level 0
        ST_DB_PRESS   = 2'd1,   // pin went active, waiting for it to stay stable
        ST_PRESSED    = 2'd2,   // press accepted, level 1, hold counter running
        ST_DB_RELEASE = 2'd3    // pin went inactive, waiting for it to stay stable
    } key_state_e;

    // Ceiling log2; clog2(1) = 0, clog2(17) = 5.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// -----------------------------------------------------------------------------
// key_debounce_if
//   Bundles the raw key pins and the conditioned key events.
//   There is no valid/ready handshake: key_press_o, key_release_o and
//   key_long_o are single-cycle pulses in the sys_clk domain that the consumer
//   must sample on the cycle they are high; there is no backpressure.
//   key_level_o and press_cnt_o are level outputs, stable between events.
//
//   key_i         raw asynchronous key pins
//   key_level_o   debounced level, 1 = pressed
//   key_press_o   1-cycle pulse on accepted press
//   key_release_o 1-cycle pulse on accepted release
//   key_long_o    1-cycle pulse once per press when held long enough
//   press_cnt_o   per-key press count, key k at [8k+7:8k]
//   state_dbg     per-key FSM state, key k at [2k+1:2k]
//
//   master : the debouncer (consumes pins, drives events)
//   slave  : user logic observing the events
// -----------------------------------------------------------------------------
interface key_debounce_if #(
    parameter int NUM_KEYS = 2
);
    import key_debounce_pkg::*;

    logic [NUM_KEYS-1:0]             key_i;
    logic [NUM_KEYS-1:0]             key_level_o;
    logic [NUM_KEYS-1:0]             key_press_o;
    logic [NUM_KEYS-1:0]             key_release_o;
    logic [NUM_KEYS-1:0]             key_long_o;
    logic [PRESS_CNT_W*NUM_KEYS-1:0] press_cnt_o;
    logic [2*NUM_KEYS-1:0]           state_dbg;

    modport master (
        input  key_i,
        output key_level_o,
        output key_press_o,
        output key_release_o,
        output key_long_o,
        output press_cnt_o,
        output state_dbg
    );

    modport slave (
        input  key_i,
        input  key_level_o,
        input  key_press_o,
        input  key_release_o,
        input  key_long_o,
        input  press_cnt_o,
        input  state_dbg
    );

endinterface

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//   One key channel: 2-FF synchroniser, polarity normalisation, debounce FSM,
//   hold counter for long-press detection and a wrapping press counter.
//
//   sys_clk      system clock
//   sys_rst_n    asynchronous active-low reset
//   key_pin      raw asynchronous key pin
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_long     1-cycle pulse once per press after LONG_CYC held cycles
//   press_cnt    accepted-press count, wraps 255 -> 0
//   state_dbg    current FSM state
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int LONG_CYC       = 50_000_000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   key_pin,
    output logic                   key_level,
    output logic                   key_press,
    output logic                   key_release,
    output logic                   key_long,
    output logic [PRESS_CNT_W-1:0] press_cnt,
    output key_state_e             state_dbg
);

    localparam int               CNT_W     = clog2(LONG_CYC + 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
    // Pin level when the key is not pressed; the synchroniser resets to this
    // so that leaving reset never looks like a press edge.
    localparam logic             PIN_IDLE  = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             sync_q1;
    logic             sync_q2;
    logic             act;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold;
    logic             long_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= PIN_IDLE;
            sync_q2 <= PIN_IDLE;
        end else begin
            sync_q1 <= key_pin;
            sync_q2 <= sync_q1;
        end
    end

    // act = 1 means the key is currently seen as pressed.
    assign act = KEY_ACTIVE_LOW ? ~sync_q2 : sync_q2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hold        <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            press_cnt   <= '0;
        end else begin
            // Event outputs are pulses: low unless set below this cycle.
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;

            // The hold counter runs in both pressed states so that a release
            // bounce neither restarts nor loses the long-press timing. It
            // saturates at HOLD_LAST and long_done limits the pulse to one
            // per accepted press.
            if (state == ST_PRESSED || state == ST_DB_RELEASE) begin
                if (hold != HOLD_LAST) begin
                    hold <= hold + 1'b1;
                end else if (!long_done) begin
                    key_long  <= 1'b1;
                    long_done <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    key_level <= 1'b0;
                    if (act) begin
                        state <= ST_DB_PRESS;
                        cnt   <= '0;
                    end
                end

                ST_DB_PRESS: begin
                    if (!act) begin
                        state <= ST_IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= ST_PRESSED;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                        press_cnt <= press_cnt + 1'b1;
                        hold      <= '0;
                        long_done <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_PRESSED: begin
                    key_level <= 1'b1;
                    if (!act) begin
                        state <= ST_DB_RELEASE;
                        cnt   <= '0;
                    end
                end

                ST_DB_RELEASE: begin
                    if (act) begin
                        // Release bounce: back to pressed, long_done kept.
                        state <= ST_PRESSED;
                    end else if (cnt == DB_LAST) begin
                        state       <= ST_IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                        long_done   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Conditions NUM_KEYS raw push-button pins into clean sys_clk-domain events:
//   debounced level, press/release/long-press pulses and a wrapping press
//   count per key. Channels are fully independent.
//
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   kif        key_debounce_if.master (key_i in; level, pulses, counts and
//              per-key FSM state out)
// -----------------------------------------------------------------------------
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS       = 2,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int LONG_CYC       = 50_000_000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    key_debounce_if.master kif
);

    if (NUM_KEYS < 1) begin : g_bad_num_keys
        $error("key_debounce: NUM_KEYS must be at least 1");
    end
    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYC must be at least 2");
    end
    // LONG_CYC > DEBOUNCE_CYC keeps press and long pulses in different cycles.
    if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
        $error("key_debounce: LONG_CYC must exceed DEBOUNCE_CYC");
    end

    logic [NUM_KEYS-1:0]             level_v;
    logic [NUM_KEYS-1:0]             press_v;
    logic [NUM_KEYS-1:0]             release_v;
    logic [NUM_KEYS-1:0]             long_v;
    logic [PRESS_CNT_W*NUM_KEYS-1:0] cnt_v;
    logic [2*NUM_KEYS-1:0]           state_v;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_state_e ch_state;

        key_debounce_ch #(
            .DEBOUNCE_CYC   (DEBOUNCE_CYC),
            .LONG_CYC       (LONG_CYC),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key_pin     (kif.key_i[k]),
            .key_level   (level_v[k]),
            .key_press   (press_v[k]),
            .key_release (release_v[k]),
            .key_long    (long_v[k]),
            .press_cnt   (cnt_v[PRESS_CNT_W*k +: PRESS_CNT_W]),
            .state_dbg   (ch_state)
        );

        assign state_v[2*k +: 2] = ch_state;
    end

    assign kif.key_level_o   = level_v;
    assign kif.key_press_o   = press_v;
    assign kif.key_release_o = release_v;
    assign kif.key_long_o    = long_v;
    assign kif.press_cnt_o   = cnt_v;
    assign kif.state_dbg     = state_v;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Directed bench for key_debounce with DEBOUNCE_CYC=4, LONG_CYC=16,
//   NUM_KEYS=2, active-low pins. Inputs change #1 after a rising edge, so a
//   pin change is captured at the next edge (edge N = loop index 1); outputs
//   are sampled #1 after each rising edge. A press or release is therefore
//   expected at loop index 1 + DEBOUNCE_CYC + 2 = 7.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int NUM_KEYS     = 2;
    localparam int DEBOUNCE_CYC = 4;
    localparam int LONG_CYC     = 16;
    localparam int EVT_IDX      = DEBOUNCE_CYC + 3;   // 7
    localparam int LONG_IDX     = EVT_IDX + LONG_CYC; // 23

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt [2];

    key_debounce_if #(.NUM_KEYS(NUM_KEYS)) kif ();

    key_debounce #(
        .NUM_KEYS       (NUM_KEYS),
        .DEBOUNCE_CYC   (DEBOUNCE_CYC),
        .LONG_CYC       (LONG_CYC),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kif       (kif)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        kif.key_i  = 2'b11;
        sys_rst_n  = 1'b0;
        exp_cnt[0] = 8'd0;
        exp_cnt[1] = 8'd0;
        step();
        step();
        checks++;
        if ({kif.key_level_o, kif.key_press_o, kif.key_release_o, kif.key_long_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0", {kif.key_level_o, kif.key_press_o, kif.key_release_o, kif.key_long_o});
        end
        checks++;
        if (kif.press_cnt_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_count: got %h expected 0000", kif.press_cnt_o);
        end
        checks++;
        if (kif.state_dbg !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", kif.state_dbg);
        end
        #4 sys_rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (kif.key_press_o !== 2'b00 || kif.key_level_o !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_false_press idx %0d: press %b level %b expected 00 00", i, kif.key_press_o, kif.key_level_o);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] exp_v;
        kif.key_i[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_v = (i == EVT_IDX) ? 2'b01 : 2'b00;
            checks++;
            if (kif.key_press_o !== exp_v) begin
                errors++;
                $display("FAIL clean_press_pulse idx %0d: got %b expected %b", i, kif.key_press_o, exp_v);
            end
            exp_v = (i >= EVT_IDX) ? 2'b01 : 2'b00;
            checks++;
            if (kif.key_level_o !== exp_v) begin
                errors++;
                $display("FAIL clean_press_level idx %0d: got %b expected %b", i, kif.key_level_o, exp_v);
            end
        end
        exp_cnt[0] = exp_cnt[0] + 8'd1;
        checks++;
        if (kif.press_cnt_o !== {exp_cnt[1], exp_cnt[0]}) begin
            errors++;
            $display("FAIL clean_press_count: got %h expected %h", kif.press_cnt_o, {exp_cnt[1], exp_cnt[0]});
        end
        checks++;
        if (kif.state_dbg !== 4'b0010) begin
            errors++;
            $display("FAIL clean_press_state: got %b expected 0010", kif.state_dbg);
        end
        kif.key_i[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_v = (i == EVT_IDX) ? 2'b01 : 2'b00;
            checks++;
            if (kif.key_release_o !== exp_v || kif.key_long_o !== 2'b00) begin
                errors++;
                $display("FAIL clean_release_pulse idx %0d: release %b long %b expected %b 00", i, kif.key_release_o, kif.key_long_o, exp_v);
            end
            exp_v = (i >= EVT_IDX) ? 2'b00 : 2'b01;
            checks++;
            if (kif.key_level_o !== exp_v) begin
                errors++;
                $display("FAIL clean_release_level idx %0d: got %b expected %b", i, kif.key_level_o, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        // Press bounce: pin low for three cycles only.
        kif.key_i[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 3) kif.key_i[0] = 1'b1;
            checks++;
            if (kif.key_press_o !== 2'b00 || kif.key_level_o !== 2'b00) begin
                errors++;
                $display("FAIL press_bounce idx %0d: press %b level %b expected 00 00", i, kif.key_press_o, kif.key_level_o);
            end
        end
        checks++;
        if (kif.press_cnt_o !== {exp_cnt[1], exp_cnt[0]}) begin
            errors++;
            $display("FAIL press_bounce_count: got %h expected %h", kif.press_cnt_o, {exp_cnt[1], exp_cnt[0]});
        end
        // Clean press, then a two-cycle release bounce.
        kif.key_i[0] = 1'b0;
        for (int i = 1; i <= 8; i++) step();
        exp_cnt[0] = exp_cnt[0] + 8'd1;
        checks++;
        if (kif.key_level_o !== 2'b01) begin
            errors++;
            $display("FAIL bounce_setup_level: got %b expected 01", kif.key_level_o);
        end
        kif.key_i[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 2) kif.key_i[0] = 1'b0;
            checks++;
            if (kif.key_release_o !== 2'b00 || kif.key_level_o !== 2'b01) begin
                errors++;
                $display("FAIL release_bounce idx %0d: release %b level %b expected 00 01", i, kif.key_release_o, kif.key_level_o);
            end
        end
        kif.key_i[0] = 1'b1;
        for (int i = 1; i <= 12; i++) step();
        checks++;
        if (kif.key_level_o !== 2'b00 || kif.press_cnt_o !== {exp_cnt[1], exp_cnt[0]}) begin
            errors++;
            $display("FAIL bounce_final: level %b count %h expected 00 %h", kif.key_level_o, kif.press_cnt_o, {exp_cnt[1], exp_cnt[0]});
        end
    endtask

    task automatic test_long_hold();
        logic [1:0] exp_v;
        int long_seen;
        long_seen = 0;
        kif.key_i[0] = 1'b0;
        for (int i = 1; i <= EVT_IDX + 30; i++) begin
            step();
            if (kif.key_long_o[0] === 1'b1) long_seen++;
            exp_v = (i == LONG_IDX) ? 2'b01 : 2'b00;
            checks++;
            if (kif.key_long_o !== exp_v) begin
                errors++;
                $display("FAIL long_pulse idx %0d: got %b expected %b", i, kif.key_long_o, exp_v);
            end
            exp_v = (i == EVT_IDX) ? 2'b01 : 2'b00;
            checks++;
            if (kif.key_press_o !== exp_v) begin
                errors++;
                $display("FAIL long_press_pulse idx %0d: got %b expected %b", i, kif.key_press_o, exp_v);
            end
        end
        exp_cnt[0] = exp_cnt[0] + 8'd1;
        kif.key_i[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (kif.key_long_o[0] === 1'b1) long_seen++;
            exp_v = (i == EVT_IDX) ? 2'b01 : 2'b00;
            checks++;
            if (kif.key_release_o !== exp_v) begin
                errors++;
                $display("FAIL long_release_pulse idx %0d: got %b expected %b", i, kif.key_release_o, exp_v);
            end
        end
        checks++;
        if (long_seen != 1) begin
            errors++;
            $display("FAIL long_once: got %0d pulses expected 1", long_seen);
        end
        checks++;
        if (kif.key_level_o !== 2'b00 || kif.press_cnt_o !== {exp_cnt[1], exp_cnt[0]}) begin
            errors++;
            $display("FAIL long_final: level %b count %h expected 00 %h", kif.key_level_o, kif.press_cnt_o, {exp_cnt[1], exp_cnt[0]});
        end
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        for (int n = 1; n <= 256; n++) begin
            kif.key_i[1] = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                step();
                if (kif.key_press_o[1] === 1'b1) pulses++;
            end
            kif.key_i[1] = 1'b1;
            for (int i = 1; i <= 8; i++) step();
            exp_cnt[1] = exp_cnt[1] + 8'd1;
            checks++;
            if (kif.press_cnt_o[15:8] !== exp_cnt[1]) begin
                errors++;
                $display("FAIL wrap_count press %0d: got %0d expected %0d", n, kif.press_cnt_o[15:8], exp_cnt[1]);
            end
        end
        checks++;
        if (kif.press_cnt_o[15:8] !== 8'd0) begin
            errors++;
            $display("FAIL wrap_to_zero: got %0d expected 0", kif.press_cnt_o[15:8]);
        end
        checks++;
        if (pulses != 256) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d expected 256", pulses);
        end
        checks++;
        if (kif.press_cnt_o[7:0] !== exp_cnt[0]) begin
            errors++;
            $display("FAIL wrap_other_key: got %0d expected %0d", kif.press_cnt_o[7:0], exp_cnt[0]);
        end
    endtask

    task automatic test_reset_mid_hold();
        int pulses;
        kif.key_i[0] = 1'b0;
        for (int i = 1; i <= 11; i++) step();
        #3 sys_rst_n = 1'b0;
        #1;
        exp_cnt[0] = 8'd0;
        exp_cnt[1] = 8'd0;
        checks++;
        if ({kif.key_level_o, kif.key_press_o, kif.key_release_o, kif.key_long_o} !== 8'h00 ||
            kif.press_cnt_o !== 16'h0000 || kif.state_dbg !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_hold_outputs: flags %b count %h state %h expected 0",
                     {kif.key_level_o, kif.key_press_o, kif.key_release_o, kif.key_long_o}, kif.press_cnt_o, kif.state_dbg);
        end
        step();
        step();
        // Release reset with the key still held: a fresh press must follow.
        #4 sys_rst_n = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (kif.key_press_o[0] === 1'b1) pulses++;
        end
        exp_cnt[0] = 8'd1;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL reset_held_press: got %0d pulses expected 1", pulses);
        end
        checks++;
        if (kif.key_level_o !== 2'b01 || kif.press_cnt_o !== {exp_cnt[1], exp_cnt[0]}) begin
            errors++;
            $display("FAIL reset_held_state: level %b count %h expected 01 %h", kif.key_level_o, kif.press_cnt_o, {exp_cnt[1], exp_cnt[0]});
        end
        kif.key_i[0] = 1'b1;
        for (int i = 1; i <= 10; i++) step();
        // Reset with the key up: nothing must happen afterwards.
        #3 sys_rst_n = 1'b0;
        exp_cnt[0] = 8'd0;
        step();
        #4 sys_rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (kif.key_press_o !== 2'b00 || kif.key_level_o !== 2'b00) begin
                errors++;
                $display("FAIL reset_released idx %0d: press %b level %b expected 00 00", i, kif.key_press_o, kif.key_level_o);
            end
        end
        checks++;
        if (kif.press_cnt_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_released_count: got %h expected 0000", kif.press_cnt_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_v;
        // One solo press on key 0 so the two counts differ.
        kif.key_i[0] = 1'b0;
        for (int i = 1; i <= 8; i++) step();
        kif.key_i[0] = 1'b1;
        for (int i = 1; i <= 8; i++) step();
        exp_cnt[0] = exp_cnt[0] + 8'd1;
        kif.key_i = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_v = (i == EVT_IDX) ? 2'b11 : 2'b00;
            checks++;
            if (kif.key_press_o !== exp_v) begin
                errors++;
                $display("FAIL simultaneous_press idx %0d: got %b expected %b", i, kif.key_press_o, exp_v);
            end
        end
        exp_cnt[0] = exp_cnt[0] + 8'd1;
        exp_cnt[1] = exp_cnt[1] + 8'd1;
        checks++;
        if (kif.press_cnt_o !== {exp_cnt[1], exp_cnt[0]}) begin
            errors++;
            $display("FAIL simultaneous_count: got %h expected %h", kif.press_cnt_o, {exp_cnt[1], exp_cnt[0]});
        end
        checks++;
        if (kif.key_level_o !== 2'b11) begin
            errors++;
            $display("FAIL simultaneous_level: got %b expected 11", kif.key_level_o);
        end
        kif.key_i = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_v = (i == EVT_IDX) ? 2'b11 : 2'b00;
            checks++;
            if (kif.key_release_o !== exp_v) begin
                errors++;
                $display("FAIL simultaneous_release idx %0d: got %b expected %b", i, kif.key_release_o, exp_v);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        kif.key_i = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_wrap();
        test_reset_mid_hold();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
